// File: rtl/multicycle_control.sv
// Moore control FSM for the RV32I multicycle datapath: 2-5 cycles per instruction.
// No backpressure; write strobes and illegal are gated low combinationally while reset is high.
module multicycle_control (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic        funct7b5,
  input  logic        zero,
  output logic        pcWrite,
  output logic        adrSrc,
  output logic        memWrite,
  output logic        irWrite,
  output logic        regWrite,
  output logic [1:0]  resultSrc,
  output logic [1:0]  aluSrcA,
  output logic [1:0]  aluSrcB,
  output logic [1:0]  immSrc,
  output logic [2:0]  ALUcontrol,
  output logic        illegal,
  output logic [31:0] instret
);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_RTYP = 7'b0110011;
  localparam logic [6:0] OP_ITYP = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECUTER, EXECUTEI, ALUWB, BEQ, JAL
  } state_t;

  typedef struct packed {
    logic       pcupdate;
    logic       branch;
    logic       adrsrc;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic [1:0] resultsrc;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
  } ctrl_t;

  state_t state;
  state_t next_state;
  ctrl_t  ctrl_q;
  logic   retire;

  // Control word for a state; registered alongside the state so outputs come straight from flops.
  function automatic ctrl_t state_ctrl(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.irwrite   = 1'b1;
        c.alusrcb   = 2'b10;
        c.resultsrc = 2'b10;
        c.pcupdate  = 1'b1;
      end
      DECODE: begin
        c.alusrca = 2'b01;
        c.alusrcb = 2'b01;
      end
      MEMADR: begin
        c.alusrca = 2'b10;
        c.alusrcb = 2'b01;
      end
      MEMREAD: begin
        c.adrsrc = 1'b1;
      end
      MEMWB: begin
        c.resultsrc = 2'b01;
        c.regwrite  = 1'b1;
      end
      MEMWRITE: begin
        c.adrsrc   = 1'b1;
        c.memwrite = 1'b1;
      end
      EXECUTER: begin
        c.alusrca = 2'b10;
        c.aluop   = 2'b10;
      end
      EXECUTEI: begin
        c.alusrca = 2'b10;
        c.alusrcb = 2'b01;
        c.aluop   = 2'b10;
      end
      ALUWB: begin
        c.regwrite = 1'b1;
      end
      BEQ: begin
        c.alusrca = 2'b10;
        c.aluop   = 2'b01;
        c.branch  = 1'b1;
      end
      JAL: begin
        c.alusrca  = 2'b01;
        c.alusrcb  = 2'b10;
        c.pcupdate = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    next_state = FETCH;
    case (state)
      FETCH:  next_state = DECODE;
      DECODE: begin
        case (opcode)
          OP_LW, OP_SW: next_state = MEMADR;
          OP_RTYP:      next_state = EXECUTER;
          OP_ITYP:      next_state = EXECUTEI;
          OP_BEQ:       next_state = BEQ;
          OP_JAL:       next_state = JAL;
          default:      next_state = FETCH;
        endcase
      end
      // opcode[5] separates sw from lw
      MEMADR:   next_state = opcode[5] ? MEMWRITE : MEMREAD;
      MEMREAD:  next_state = MEMWB;
      EXECUTER: next_state = ALUWB;
      EXECUTEI: next_state = ALUWB;
      JAL:      next_state = ALUWB;
      default:  next_state = FETCH;
    endcase
  end

  assign retire = (state == MEMWB) || (state == MEMWRITE) ||
                  (state == ALUWB) || (state == BEQ);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= FETCH;
      ctrl_q  <= state_ctrl(FETCH);
      instret <= 32'd0;
    end else begin
      state  <= next_state;
      ctrl_q <= state_ctrl(next_state);
      if (retire)
        instret <= instret + 32'd1;
    end
  end

  assign pcWrite   = ~reset & (ctrl_q.pcupdate | (ctrl_q.branch & zero));
  assign irWrite   = ~reset & ctrl_q.irwrite;
  assign memWrite  = ~reset & ctrl_q.memwrite;
  assign regWrite  = ~reset & ctrl_q.regwrite;
  assign adrSrc    = ctrl_q.adrsrc;
  assign resultSrc = ctrl_q.resultsrc;
  assign aluSrcA   = ctrl_q.alusrca;
  assign aluSrcB   = ctrl_q.alusrcb;

  assign illegal = ~reset && (state == DECODE) &&
                   !(opcode == OP_LW   || opcode == OP_SW  || opcode == OP_RTYP ||
                     opcode == OP_ITYP || opcode == OP_BEQ || opcode == OP_JAL);

  always_comb begin
    case (opcode)
      OP_SW:   immSrc = 2'b01;
      OP_BEQ:  immSrc = 2'b10;
      OP_JAL:  immSrc = 2'b11;
      default: immSrc = 2'b00;
    endcase
  end

  // Subtract only for R-type with funct7b5; addi ignores instr[30].
  always_comb begin
    ALUcontrol = 3'b000;
    case (ctrl_q.aluop)
      2'b01: ALUcontrol = 3'b001;
      2'b10: begin
        case (funct3)
          3'b000:  ALUcontrol = (opcode[5] & funct7b5) ? 3'b001 : 3'b000;
          3'b010:  ALUcontrol = 3'b101;
          3'b110:  ALUcontrol = 3'b011;
          3'b111:  ALUcontrol = 3'b010;
          default: ALUcontrol = 3'b000;
        endcase
      end
      default: ALUcontrol = 3'b000;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class cycle by cycle.
module tb_multicycle_control;

  logic        clk;
  logic        reset;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7b5;
  logic        zero;
  logic        pcWrite, adrSrc, memWrite, irWrite, regWrite, illegal;
  logic [1:0]  resultSrc, aluSrcA, aluSrcB, immSrc;
  logic [2:0]  ALUcontrol;
  logic [31:0] instret;

  int checks = 0;
  int errors = 0;

  // {pcWrite,adrSrc,memWrite,irWrite,regWrite,resultSrc,aluSrcA,aluSrcB,ALUcontrol}
  logic [13:0] ctl;
  assign ctl = {pcWrite, adrSrc, memWrite, irWrite, regWrite,
                resultSrc, aluSrcA, aluSrcB, ALUcontrol};

  localparam logic [13:0] C_FETCH    = 14'b1_0_0_1_0_10_00_10_000;
  localparam logic [13:0] C_DECODE   = 14'b0_0_0_0_0_00_01_01_000;
  localparam logic [13:0] C_MEMADR   = 14'b0_0_0_0_0_00_10_01_000;
  localparam logic [13:0] C_MEMREAD  = 14'b0_1_0_0_0_00_00_00_000;
  localparam logic [13:0] C_MEMWB    = 14'b0_0_0_0_1_01_00_00_000;
  localparam logic [13:0] C_MEMWRITE = 14'b0_1_1_0_0_00_00_00_000;
  localparam logic [13:0] C_ALUWB    = 14'b0_0_0_0_1_00_00_00_000;
  localparam logic [13:0] C_JAL      = 14'b1_0_0_0_0_00_01_10_000;

  multicycle_control dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3),
    .funct7b5(funct7b5), .zero(zero), .pcWrite(pcWrite), .adrSrc(adrSrc),
    .memWrite(memWrite), .irWrite(irWrite), .regWrite(regWrite),
    .resultSrc(resultSrc), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB),
    .immSrc(immSrc), .ALUcontrol(ALUcontrol), .illegal(illegal),
    .instret(instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next falling edge, well clear of the rising edge.
  task automatic cyc;
    @(negedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; opcode = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0; zero = 1'b0;

    cyc();
    chk("rst_irwrite", {31'd0, irWrite}, 32'd0);
    chk("rst_pcwrite", {31'd0, pcWrite}, 32'd0);
    chk("rst_instret", instret, 32'd0);
    cyc();
    reset = 1'b0; opcode = 7'b0000011; #1;
    chk("fetch_ctl", {18'd0, ctl}, {18'd0, C_FETCH});
    chk("fetch_instret", instret, 32'd0);

    // lw: 5 cycles
    cyc(); chk("lw_decode", {18'd0, ctl}, {18'd0, C_DECODE});
    chk("lw_imm", {30'd0, immSrc}, 32'd0);
    cyc(); chk("lw_memadr", {18'd0, ctl}, {18'd0, C_MEMADR});
    cyc(); chk("lw_memread", {18'd0, ctl}, {18'd0, C_MEMREAD});
    cyc(); chk("lw_memwb", {18'd0, ctl}, {18'd0, C_MEMWB});
    chk("lw_instret_before", instret, 32'd0);
    cyc(); chk("lw_back_fetch", {18'd0, ctl}, {18'd0, C_FETCH});
    chk("lw_instret", instret, 32'd1);

    // add
    opcode = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b0;
    cyc(); chk("add_decode", {18'd0, ctl}, {18'd0, C_DECODE});
    cyc(); chk("add_exec", {18'd0, ctl}, {18'd0, 14'b0_0_0_0_0_00_10_00_000});
    cyc(); chk("add_aluwb", {18'd0, ctl}, {18'd0, C_ALUWB});
    cyc(); chk("add_instret", instret, 32'd2);

    // sub
    funct7b5 = 1'b1;
    cyc(); cyc(); chk("sub_exec", {18'd0, ctl}, {18'd0, 14'b0_0_0_0_0_00_10_00_001});
    cyc(); chk("sub_aluwb", {18'd0, ctl}, {18'd0, C_ALUWB});
    cyc(); chk("sub_instret", instret, 32'd3);

    // addi with instr[30] set must still add
    opcode = 7'b0010011; funct3 = 3'b000; funct7b5 = 1'b1;
    cyc(); chk("addi_imm", {30'd0, immSrc}, 32'd0);
    cyc(); chk("addi_exec", {18'd0, ctl}, {18'd0, 14'b0_0_0_0_0_00_10_01_000});
    cyc(); cyc(); chk("addi_instret", instret, 32'd4);

    // slti
    funct3 = 3'b010; funct7b5 = 1'b0;
    cyc(); cyc(); chk("slti_exec", {18'd0, ctl}, {18'd0, 14'b0_0_0_0_0_00_10_01_101});
    cyc(); cyc(); chk("slti_instret", instret, 32'd5);

    // R-type and, then or checked combinationally in the same EXECUTER cycle
    opcode = 7'b0110011; funct3 = 3'b111;
    cyc(); cyc(); chk("and_exec", {29'd0, ALUcontrol}, 32'd2);
    funct3 = 3'b110; #1;
    chk("or_exec", {29'd0, ALUcontrol}, 32'd3);
    cyc(); cyc(); chk("and_instret", instret, 32'd6);

    // beq taken
    opcode = 7'b1100011; funct3 = 3'b000;
    cyc(); chk("beq_imm", {30'd0, immSrc}, 32'd2);
    cyc(); zero = 1'b1; #1;
    chk("beq_taken", {18'd0, ctl}, {18'd0, 14'b1_0_0_0_0_00_10_00_001});
    cyc(); zero = 1'b0; #1;
    chk("beq_t_fetch", {18'd0, ctl}, {18'd0, C_FETCH});
    chk("beq_t_instret", instret, 32'd7);

    // beq not taken
    cyc(); cyc();
    chk("beq_nt_pcwrite", {31'd0, pcWrite}, 32'd0);
    cyc(); chk("beq_nt_instret", instret, 32'd8);

    // jal
    opcode = 7'b1101111;
    cyc(); chk("jal_imm", {30'd0, immSrc}, 32'd3);
    cyc(); chk("jal_ctl", {18'd0, ctl}, {18'd0, C_JAL});
    cyc(); chk("jal_aluwb", {18'd0, ctl}, {18'd0, C_ALUWB});
    cyc(); chk("jal_instret", instret, 32'd9);

    // illegal opcode
    opcode = 7'b1111111; #1;
    chk("ill_fetch", {31'd0, illegal}, 32'd0);
    cyc(); chk("ill_decode", {31'd0, illegal}, 32'd1);
    chk("ill_imm", {30'd0, immSrc}, 32'd0);
    cyc(); chk("ill_back_fetch", {18'd0, ctl}, {18'd0, C_FETCH});
    chk("ill_pulse_end", {31'd0, illegal}, 32'd0);
    chk("ill_instret", instret, 32'd9);

    // sw complete
    opcode = 7'b0100011; funct3 = 3'b010;
    cyc(); chk("sw_imm", {30'd0, immSrc}, 32'd1);
    cyc(); chk("sw_memadr", {18'd0, ctl}, {18'd0, C_MEMADR});
    cyc(); chk("sw_memwrite", {18'd0, ctl}, {18'd0, C_MEMWRITE});
    cyc(); chk("sw_instret", instret, 32'd10);

    // sw aborted by reset in MEMADR
    cyc(); cyc(); reset = 1'b1; #1;
    chk("swrst_memwrite", {31'd0, memWrite}, 32'd0);
    cyc(); reset = 1'b0; #1;
    chk("swrst_fetch", {18'd0, ctl}, {18'd0, C_FETCH});
    chk("swrst_instret", instret, 32'd0);

    // lw aborted by reset in MEMWB: regWrite must drop immediately
    opcode = 7'b0000011;
    cyc(); cyc(); cyc(); cyc();
    chk("lwrst_memwb", {18'd0, ctl}, {18'd0, C_MEMWB});
    reset = 1'b1; #1;
    chk("lwrst_regwrite", {31'd0, regWrite}, 32'd0);
    cyc(); reset = 1'b0; #1;
    chk("lwrst_fetch", {18'd0, ctl}, {18'd0, C_FETCH});
    chk("lwrst_instret", instret, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multicycle control unit for the RV32I subset core. It drives the shared-memory multicycle datapath and replaces the single-cycle decoder. A Moore FSM sequences each instruction through fetch, decode, execute, memory and writeback. It also provides per-instruction write strobes, ALU control and a retired-instruction counter.

## Interface
Parameters:
- none

Ports:
- clk  in  1  core clock; all state changes on rising edge
- reset  in  1  synchronous, active-high; one clock, synchronous reset, active-high
- opcode  in  7  instr[6:0] from the instruction register
- funct3  in  3  instr[14:12]
- funct7b5  in  1  instr[30]
- zero  in  1  ALU zero flag, current cycle
- pcWrite  out  1  PC register load enable
- adrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut
- memWrite  out  1  memory write enable
- irWrite  out  1  instruction register / oldPC load enable
- regWrite  out  1  register file write enable
- resultSrc  out  2  result mux select: 00 = ALUOut, 01 = Data, 10 = ALUResult
- aluSrcA  out  2  SrcA select: 00 = PC, 01 = oldPC, 10 = rs1 (A register)
- aluSrcB  out  2  SrcB select: 00 = rs2 (WriteData register), 01 = immExt, 10 = constant 4
- immSrc  out  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J
- ALUcontrol  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- illegal  out  1  one-cycle pulse when an unsupported opcode is decoded
- instret  out  32  count of retired instructions

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BEQ, JAL.
- Unlisted outputs are 0 in every state; aluOp is an internal 2-bit signal.
- FETCH:
  - adrSrc=0, irWrite=1, aluSrcA=00, aluSrcB=10, aluOp=00, resultSrc=10, pcUpdate=1.
  - Next state: DECODE.
- DECODE: aluSrcA=01, aluSrcB=01, aluOp=00. Next state by opcode:
  - 0000011 (lw) or 0100011 (sw) → MEMADR
  - 0110011 → EXECUTER
  - 0010011 → EXECUTEI
  - 1100011 → BEQ
  - 1101111 → JAL
  - any other → FETCH, with illegal=1 in that DECODE cycle
- MEMADR: aluSrcA=10, aluSrcB=01, aluOp=00. Next state: MEMREAD if lw, MEMWRITE if sw.
- MEMREAD: resultSrc=00, adrSrc=1. Next state: MEMWB.
- MEMWB: resultSrc=01, regWrite=1. Next state: FETCH.
- MEMWRITE: resultSrc=00, adrSrc=1, memWrite=1. Next state: FETCH.
- EXECUTER: aluSrcA=10, aluSrcB=00, aluOp=10. Next state: ALUWB.
- EXECUTEI: aluSrcA=10, aluSrcB=01, aluOp=10. Next state: ALUWB.
- ALUWB: resultSrc=00, regWrite=1. Next state: FETCH.
- BEQ:
  - aluSrcA=10, aluSrcB=00, aluOp=01, resultSrc=00, branch=1.
  - Next state: FETCH.
- JAL: aluSrcA=01, aluSrcB=10, aluOp=00, resultSrc=00, pcUpdate=1. Next state: ALUWB.
- pcWrite = pcUpdate | (branch & zero).
- immSrc is combinational from opcode in every state:
  - lw and I-type → 00
  - sw → 01
  - beq → 10
  - jal → 11
  - other → 00
- ALU decode:
  - aluOp 00 → add; aluOp 01 → sub.
  - aluOp 10, funct3 000 → sub if opcode[5] & funct7b5, else add.
  - aluOp 10, funct3 010 → slt; 110 → or; 111 → and.
  - aluOp 10, any other funct3 → add.
- instret:
  - Increments by 1 on the clock edge leaving MEMWB, MEMWRITE, ALUWB or BEQ.
  - JAL retires via ALUWB.
  - Illegal opcodes are not counted.
  - Wraps from 0xFFFFFFFF to 0x00000000.

## Timing
- While reset=1 at a rising edge: state ← FETCH and instret ← 0.
- While reset=1, pcWrite, irWrite, memWrite, regWrite and illegal are forced to 0 combinationally.
- The first cycle after reset deasserts is FETCH.
- Outputs are combinational from state, except:
  - pcWrite, which also depends on zero;
  - ALUcontrol, which also depends on funct3, funct7b5 and opcode[5];
  - immSrc and illegal, which also depend on opcode.
- Cycles per instruction:
  - lw 5
  - sw 4
  - R-type 4
  - I-type 4
  - jal 4
  - beq 3
  - illegal 2
- Reset asserted mid-instruction aborts it: no write strobe is issued after that edge, and instret does not count the aborted instruction.
- opcode and funct fields must stay stable from DECODE to the end of the instruction; the IR is written only in FETCH.

## Test plan
- Reset held 2 cycles, then released → FETCH outputs: irWrite=1, pcWrite=1, aluSrcB=10, resultSrc=10; instret=0.
- lw (opcode 0000011) → state sequence FETCH, DECODE, MEMADR, MEMREAD, MEMWB:
  - regWrite=1 only in cycle 5, with resultSrc=01;
  - instret goes 0→1 at the end of cycle 5.
- add, then sub (0110011, funct3=000, funct7b5=0/1) → ALUcontrol=000, then 001, in EXECUTER; regWrite=1 in ALUWB; instret +1 per instruction.
- beq with zero=1 → pcWrite=1 in cycle 3; beq with zero=0 → pcWrite=0 in cycle 3; both return to FETCH and increment instret.
- opcode 1111111 → illegal=1 for exactly one cycle in DECODE, next state FETCH, instret unchanged.
- sw with reset asserted during MEMADR → memWrite never asserts, next state FETCH, instret=0.
